// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional two's-complement input handled as sign plus magnitude.
module bin_to_bcd_seq #(
    parameter int WIDTH     = 8,
    parameter int DIGITS    = 3,
    parameter bit SIGNED_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic                  signed_op,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   y,
    output logic                  neg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int VW = WIDTH + 4;

    // Decimal digits needed for the largest WIDTH-bit unsigned value.
    function automatic int digits_needed();
        logic [VW-1:0] v;
        int            n;
        v = {4'b0000, {WIDTH{1'b1}}};
        n = 0;
        while (v != '0) begin
            v = v / VW'(10);
            n = n + 1;
        end
        return n;
    endfunction

    localparam int NEED = digits_needed();

    generate
        if (WIDTH < 2 || DIGITS < NEED) begin : g_param_check
            $error("bin_to_bcd_seq: WIDTH must be >= 2 and DIGITS large enough for 2**WIDTH-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [4*DIGITS-1:0]   acc_reg, acc_next, acc_adj;
    logic [WIDTH-1:0]      mag_reg, mag_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  neg_q_reg, neg_q_next;
    logic [4*DIGITS-1:0]   y_reg;
    logic                  neg_reg;
    logic                  done_reg;
    logic                  take_neg;

    // Add-3 correction on every digit that would overflow past 9 after doubling.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                        acc_reg[4*gi +: 4] + 4'd3 :
                                        acc_reg[4*gi +: 4];
        end
    endgenerate

    assign take_neg = SIGNED_EN && signed_op && a[WIDTH-1];

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        mag_next   = mag_reg;
        cnt_next   = cnt_reg;
        neg_q_next = neg_q_reg;
        case (state_reg)
            IDLE, FIN: begin
                if (state_reg == FIN) begin
                    state_next = IDLE;
                end
                if (start) begin
                    state_next = SHIFT;
                    acc_next   = '0;
                    // Negation wraps so the most negative value maps to 2**(WIDTH-1).
                    mag_next   = take_neg ? WIDTH'(~a + 1'b1) : a;
                    cnt_next   = CW'(WIDTH);
                    neg_q_next = take_neg;
                end
            end
            SHIFT: begin
                acc_next = {acc_adj[4*DIGITS-2:0], mag_reg[WIDTH-1]};
                mag_next = {mag_reg[WIDTH-2:0], 1'b0};
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    state_next = FIN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            mag_reg   <= '0;
            cnt_reg   <= '0;
            neg_q_reg <= 1'b0;
            y_reg     <= '0;
            neg_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            mag_reg   <= mag_next;
            cnt_reg   <= cnt_next;
            neg_q_reg <= neg_q_next;
            done_reg  <= (state_reg == FIN);
            if (state_reg == FIN) begin
                y_reg   <= acc_reg;
                neg_reg <= neg_q_reg;
            end
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign y    = y_reg;
    assign neg  = neg_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: an 8-bit signed-capable instance and a 16-bit unsigned one.
// Expected BCD comes from repeated division by ten on the operand magnitude.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic        busy8, done8, neg8;
    logic [11:0] y8;

    logic        start16 = 1'b0, sgn16 = 1'b0;
    logic [15:0] a16 = '0;
    logic        busy16, done16, neg16;
    logic [19:0] y16;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [19:0] y;
        logic        neg;
        int          due;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   c0_8 = -100, c0_16 = -100;
    int   free8 = 0, free16 = 0;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED_EN(1'b1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .signed_op(sgn8),
        .busy(busy8), .done(done8), .y(y8), .neg(neg8)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_EN(1'b0)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .signed_op(sgn16),
        .busy(busy16), .done(done16), .y(y16), .neg(neg16)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input longint unsigned v);
        logic [19:0] r;
        longint unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference model: decides acceptance from its own notion of when each unit is free.
    exp_t            e8m, e16m;
    longint unsigned m8;
    logic            n8;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            q8.delete();
            q16.delete();
            c0_8 = -100; c0_16 = -100;
            free8 = 0;   free16 = 0;
        end else begin
            if (start8 && cyc >= free8) begin
                n8 = sgn8 && a8[7];
                m8 = n8 ? (longint'(256) - longint'(a8)) : longint'(a8);
                e8m.y = to_bcd(m8);
                e8m.neg = n8;
                e8m.due = cyc + 9;
                q8.push_back(e8m);
                c0_8 = cyc;
                free8 = cyc + 9;
            end
            if (start16 && cyc >= free16) begin
                e16m.y = to_bcd(longint'(a16));
                e16m.neg = 1'b0;
                e16m.due = cyc + 17;
                q16.push_back(e16m);
                c0_16 = cyc;
                free16 = cyc + 17;
            end
        end
    end

    exp_t e8, e16;
    logic busy8_exp, busy16_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            busy8_exp = (cyc >= c0_8) && (cyc <= c0_8 + 7);
            checks++;
            if (busy8 !== busy8_exp) begin
                errors++;
                $display("FAIL busy8 cyc=%0d: got %b, expected %b", cyc, busy8, busy8_exp);
            end
            busy16_exp = (cyc >= c0_16) && (cyc <= c0_16 + 15);
            checks++;
            if (busy16 !== busy16_exp) begin
                errors++;
                $display("FAIL busy16 cyc=%0d: got %b, expected %b", cyc, busy16, busy16_exp);
            end

            if (done8) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL done8_unexpected cyc=%0d: got y=%h neg=%b, expected no done", cyc, y8, neg8);
                end else begin
                    e8 = q8.pop_front();
                    if (y8 !== e8.y[11:0] || neg8 !== e8.neg || cyc != e8.due) begin
                        errors++;
                        $display("FAIL result8 cyc=%0d: got y=%h neg=%b, expected y=%h neg=%b at cyc %0d",
                                 cyc, y8, neg8, e8.y[11:0], e8.neg, e8.due);
                    end
                end
            end else if (q8.size() > 0 && q8[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL done8_missing cyc=%0d: got no done, expected y=%h", cyc, q8[0].y[11:0]);
                void'(q8.pop_front());
            end

            if (done16) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL done16_unexpected cyc=%0d: got y=%h neg=%b, expected no done", cyc, y16, neg16);
                end else begin
                    e16 = q16.pop_front();
                    if (y16 !== e16.y || neg16 !== e16.neg || cyc != e16.due) begin
                        errors++;
                        $display("FAIL result16 cyc=%0d: got y=%h neg=%b, expected y=%h neg=%b at cyc %0d",
                                 cyc, y16, neg16, e16.y, e16.neg, e16.due);
                    end
                end
            end else if (q16.size() > 0 && q16[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL done16_missing cyc=%0d: got no done, expected y=%h", cyc, q16[0].y);
                void'(q16.pop_front());
            end
        end
    end

    task automatic expect8(input logic [11:0] ey, input logic en, input string nm);
        checks++;
        if (y8 !== ey || neg8 !== en) begin
            errors++;
            $display("FAIL %s: got y=%h neg=%b, expected y=%h neg=%b", nm, y8, neg8, ey, en);
        end else begin
            $display("ok %s: y=%h neg=%b", nm, y8, neg8);
        end
    endtask

    task automatic expect16(input logic [19:0] ey, input string nm);
        checks++;
        if (y16 !== ey || neg16 !== 1'b0) begin
            errors++;
            $display("FAIL %s: got y=%h neg=%b, expected y=%h neg=0", nm, y16, neg16, ey);
        end else begin
            $display("ok %s: y=%h", nm, y16);
        end
    endtask

    task automatic expect_bit(input logic got, input logic want, input string nm);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, got, want);
        end
    endtask

    // Called at a negedge; raises start for one cycle, then waits for the result.
    task automatic run8(input logic [7:0] v, input logic s);
        start8 = 1'b1; a8 = v; sgn8 = s;
        @(negedge clk);
        start8 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic run16(input logic [15:0] v, input logic s);
        start16 = 1'b1; a16 = v; sgn16 = s;
        @(negedge clk);
        start16 = 1'b0;
        repeat (18) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expect8(12'h000, 1'b0, "reset_y8");
        expect_bit(busy8, 1'b0, "reset_busy8");
        expect_bit(done8, 1'b0, "reset_done8");
        expect16(20'h00000, "reset_y16");
        rst_n = 1'b1;
        @(negedge clk);

        run8(8'd0, 1'b0);
        expect8(12'h000, 1'b0, "zero");

        // Back-to-back with START held through FIN.
        start8 = 1'b1; a8 = 8'd255; sgn8 = 1'b0;
        repeat (9) @(negedge clk);
        a8 = 8'd128;
        repeat (9) @(negedge clk);
        expect8(12'h255, 1'b0, "b2b_255");
        a8 = 8'd99;
        repeat (9) @(negedge clk);
        expect8(12'h128, 1'b0, "b2b_128");
        start8 = 1'b0;
        repeat (10) @(negedge clk);
        expect8(12'h099, 1'b0, "b2b_099");

        run8(8'h80, 1'b1);
        expect8(12'h128, 1'b1, "signed_80");
        run8(8'hFF, 1'b1);
        expect8(12'h001, 1'b1, "signed_ff");
        run8(8'h7F, 1'b1);
        expect8(12'h127, 1'b0, "signed_7f");
        run8(8'hFF, 1'b0);
        expect8(12'h255, 1'b0, "unsigned_ff");

        // START pulses while busy must be ignored.
        start8 = 1'b1; a8 = 8'd42; sgn8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        expect8(12'h042, 1'b0, "ignored_start");

        // Reset mid-conversion.
        start8 = 1'b1; a8 = 8'd200;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect8(12'h000, 1'b0, "abort_y");
        expect_bit(busy8, 1'b0, "abort_busy");
        expect_bit(done8, 1'b0, "abort_done");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run8(8'd200, 1'b0);
        expect8(12'h200, 1'b0, "after_abort");

        run16(16'hFFFF, 1'b0);
        expect16(20'h65535, "w16_max");
        run16(16'd1000, 1'b0);
        expect16(20'h01000, "w16_1000");
        run16(16'hFFFF, 1'b1);
        expect16(20'h65535, "w16_signed_ignored");

        // Random traffic on both units; acceptance decided by the model.
        for (int i = 0; i < 20000; i++) begin
            start8  = ($urandom_range(0, 3) != 0);
            a8      = 8'($urandom);
            sgn8    = 1'($urandom);
            start16 = ($urandom_range(0, 3) != 0);
            a16     = 16'($urandom);
            sgn16   = 1'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        start16 = 1'b0;
        repeat (20) @(negedge clk);

        checks++;
        if (q8.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending results, expected 0/0", q8.size(), q16.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
